// File: rtl/port_decl_pkg.sv
// Shared types for the non-ANSI port declaration checker: record kinds, error classes,
// FSM states, flag bit positions and the per-record classification helper.
package port_decl_pkg;

    typedef enum logic [1:0] {
        KIND_DIR = 2'd0,
        KIND_VAR = 2'd1,
        KIND_NET = 2'd2,
        KIND_END = 2'd3
    } decl_kind_e;

    typedef enum logic [2:0] {
        NONE        = 3'd0,
        PORT_MULTI  = 3'd1,
        VAR_MULTI   = 3'd2,
        NET_MULTI   = 3'd3,
        VAR_NET_MIX = 3'd4,
        MISSING_DIR = 3'd5,
        BAD_INDEX   = 3'd6
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int FLAG_DIR = 0;
    localparam int FLAG_VAR = 1;
    localparam int FLAG_NET = 2;

    // A var/net mix outranks a plain repeat, so it is tested first.
    function automatic err_code_e classify(input decl_kind_e kind, input logic in_range,
                                           input logic [2:0] old_flags);
        err_code_e code;
        code = NONE;
        if (kind != KIND_END && !in_range) begin
            code = BAD_INDEX;
        end else begin
            case (kind)
                KIND_DIR: if (old_flags[FLAG_DIR]) code = PORT_MULTI;
                KIND_VAR: begin
                    if (old_flags[FLAG_NET])      code = VAR_NET_MIX;
                    else if (old_flags[FLAG_VAR]) code = VAR_MULTI;
                end
                KIND_NET: begin
                    if (old_flags[FLAG_VAR])      code = VAR_NET_MIX;
                    else if (old_flags[FLAG_NET]) code = NET_MULTI;
                end
                default: code = NONE;
            endcase
        end
        return code;
    endfunction

    function automatic logic [2:0] kind_mask(input decl_kind_e kind);
        logic [2:0] mask;
        mask = 3'b000;
        case (kind)
            KIND_DIR: mask[FLAG_DIR] = 1'b1;
            KIND_VAR: mask[FLAG_VAR] = 1'b1;
            KIND_NET: mask[FLAG_NET] = 1'b1;
            default:  mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/port_decl_table.sv
// Per-port seen-flag array {net, var, dir} with a read-old/set-new port, a synchronous
// clear, and (when PORT_DECL_CHECKER_SCAN_EN is defined) a dir-flag scan read port.
module port_decl_table
    import port_decl_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_en,
    input  logic [2:0]       upd_set,
`ifdef PORT_DECL_CHECKER_SCAN_EN
    input  logic [IDX_W-1:0] scan_idx,
    output logic             scan_dir,
`endif
    output logic [2:0]       old_flags
);

    logic [2:0] flags_q [NUM_PORTS];

    // Index decode by comparison so out-of-range indices simply match nothing.
    always_comb begin
        old_flags = 3'b000;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (upd_idx == IDX_W'(p)) old_flags = flags_q[p];
        end
    end

`ifdef PORT_DECL_CHECKER_SCAN_EN
    always_comb begin
        scan_dir = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (scan_idx == IDX_W'(p)) scan_dir = flags_q[p][FLAG_DIR];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int p = 0; p < NUM_PORTS; p++) flags_q[p] <= 3'b000;
        end else if (upd_en) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (upd_idx == IDX_W'(p)) flags_q[p] <= flags_q[p] | upd_set;
            end
        end
    end

endmodule

// File: rtl/port_decl_checker.sv
// Streaming non-ANSI port redeclaration checker. Define PORT_DECL_CHECKER_SCAN_EN to
// add the end-of-header scan that reports ports lacking a direction (MISSING_DIR).
module port_decl_checker
    import port_decl_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             decl_valid,
    output logic             decl_ready,
    input  logic [IDX_W-1:0] decl_port,
    input  logic [1:0]       decl_kind,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [2:0]       err_code,
    output logic [IDX_W-1:0] err_port,
    output logic             done
);

    state_e     state, next_state;
    decl_kind_e kind;
    err_code_e  rec_code;
    logic       in_range, accept, slot_free, upd_en, tbl_clr, done_set;
    logic [2:0] old_flags, upd_set;

`ifdef PORT_DECL_CHECKER_SCAN_EN
    logic [IDX_W-1:0] scan_idx;
    logic             scan_dir, scan_step, scan_last, load_scan;
`endif

    assign kind     = decl_kind_e'(decl_kind);
    assign in_range = {1'b0, decl_port} < (IDX_W+1)'(NUM_PORTS);
    assign rec_code = classify(kind, in_range, old_flags);
    assign upd_en   = accept && in_range && (kind != KIND_END);
    assign upd_set  = kind_mask(kind);

    port_decl_table #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .clr       (tbl_clr),
        .upd_idx   (decl_port),
        .upd_en    (upd_en),
        .upd_set   (upd_set),
`ifdef PORT_DECL_CHECKER_SCAN_EN
        .scan_idx  (scan_idx),
        .scan_dir  (scan_dir),
`endif
        .old_flags (old_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
`ifdef PORT_DECL_CHECKER_SCAN_EN
                if (accept && kind == KIND_END) next_state = SCAN;
`endif
            end
`ifdef PORT_DECL_CHECKER_SCAN_EN
            SCAN:    if (scan_step && scan_last) next_state = FLUSH;
            FLUSH:   next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // The error slot is free when empty or retiring this cycle, which keeps streaming bubble-free.
    always_comb begin
        slot_free  = !err_valid || err_ready;
        decl_ready = !rst && (state == IDLE) && slot_free;
        accept     = decl_valid && decl_ready;
        tbl_clr    = 1'b0;
        done_set   = 1'b0;
`ifdef PORT_DECL_CHECKER_SCAN_EN
        scan_step  = 1'b0;
        load_scan  = 1'b0;
        if (state == SCAN) begin
            scan_step = scan_dir || slot_free;
            load_scan = !scan_dir && slot_free;
        end
        if (state == FLUSH) begin
            tbl_clr  = 1'b1;
            done_set = 1'b1;
        end
`else
        if (accept && kind == KIND_END) begin
            tbl_clr  = 1'b1;
            done_set = 1'b1;
        end
`endif
    end

`ifdef PORT_DECL_CHECKER_SCAN_EN
    assign scan_last = (scan_idx == IDX_W'(NUM_PORTS - 1));

    always_ff @(posedge clk) begin
        if (rst)            scan_idx <= '0;
        else if (scan_step) scan_idx <= scan_last ? '0 : scan_idx + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= NONE;
            err_port  <= '0;
        end else if (accept && rec_code != NONE) begin
            err_valid <= 1'b1;
            err_code  <= rec_code;
            err_port  <= decl_port;
`ifdef PORT_DECL_CHECKER_SCAN_EN
        end else if (load_scan) begin
            err_valid <= 1'b1;
            err_code  <= MISSING_DIR;
            err_port  <= scan_idx;
`endif
        end else if (err_ready) begin
            err_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= done_set;
    end

endmodule

// File: tb/tb_port_decl_checker.sv
// Directed self-checking bench for port_decl_checker; scan checks are compiled in when
// PORT_DECL_CHECKER_SCAN_EN is defined, otherwise END is checked for an immediate done.
module tb_port_decl_checker;
    import port_decl_pkg::*;

    localparam int NUM_PORTS = 8;
    localparam int IDX_W     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             decl_valid;
    logic             decl_ready;
    logic [IDX_W-1:0] decl_port;
    logic [1:0]       decl_kind;
    logic             err_valid;
    logic             err_ready;
    logic [2:0]       err_code;
    logic [IDX_W-1:0] err_port;
    logic             done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    port_decl_checker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .decl_valid (decl_valid),
        .decl_ready (decl_ready),
        .decl_port  (decl_port),
        .decl_kind  (decl_kind),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .err_code   (err_code),
        .err_port   (err_port),
        .done       (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one record, hold it until accepted (bounded), then release it just after the edge.
    task automatic applyStimulus(input decl_kind_e kind, input logic [IDX_W-1:0] port);
        int waited;
        waited     = 0;
        decl_valid = 1'b1;
        decl_kind  = kind;
        decl_port  = port;
        #1;
        while (!decl_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) checkOutput("ready_timeout", decl_ready, 1);
        @(posedge clk);
        #1;
        decl_valid = 1'b0;
    endtask

    task automatic expectErr(input string tag, input logic v, input logic [2:0] code,
                             input logic [IDX_W-1:0] port);
        checkOutput({tag, "_valid"}, err_valid, v);
        if (v) begin
            checkOutput({tag, "_code"}, err_code, code);
            checkOutput({tag, "_port"}, err_port, port);
        end
    endtask

`ifdef PORT_DECL_CHECKER_SCAN_EN
    logic [IDX_W-1:0] seen_ports [$];
    logic [2:0]       seen_codes [$];

    task automatic collectUntilDone(input int budget, output int cycles, output logic got_done);
        got_done = 1'b0;
        cycles   = 0;
        while (!got_done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (err_valid) begin
                seen_ports.push_back(err_port);
                seen_codes.push_back(err_code);
            end
            if (done) got_done = 1'b1;
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        decl_valid = 1'b0;
        decl_kind  = 2'd0;
        decl_port  = '0;
        err_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", decl_ready, 0);
        checkOutput("rst_err_valid", err_valid, 0);
        checkOutput("rst_err_code", err_code, 0);
        checkOutput("rst_err_port", err_port, 0);
        checkOutput("rst_done", done, 0);
        rst = 1'b0;
        #1;
        checkOutput("idle_ready", decl_ready, 1);

        // Out-of-range indices, and no aliasing of port 9 onto port 1.
        applyStimulus(KIND_DIR, 8'd9);   expectErr("bad_dir9", 1, 3'd6, 8'd9);
        applyStimulus(KIND_DIR, 8'd1);   expectErr("alias_dir1", 0, 3'd0, 8'd0);
        applyStimulus(KIND_VAR, 8'd12);  expectErr("bad_var12", 1, 3'd6, 8'd12);
        applyStimulus(KIND_NET, 8'd255); expectErr("bad_net255", 1, 3'd6, 8'd255);
        applyStimulus(KIND_DIR, 8'd8);   expectErr("bad_dir8", 1, 3'd6, 8'd8);

        applyStimulus(KIND_DIR, 8'd0);   expectErr("dir0_first", 0, 3'd0, 8'd0);
        applyStimulus(KIND_DIR, 8'd0);   expectErr("dir0_again", 1, 3'd1, 8'd0);
        applyStimulus(KIND_VAR, 8'd0);   expectErr("var0_after_dir", 0, 3'd0, 8'd0);

        applyStimulus(KIND_VAR, 8'd1);   expectErr("var1_first", 0, 3'd0, 8'd0);
        applyStimulus(KIND_VAR, 8'd1);   expectErr("var1_again", 1, 3'd2, 8'd1);
        applyStimulus(KIND_NET, 8'd1);   expectErr("net1_after_var", 1, 3'd4, 8'd1);

        applyStimulus(KIND_DIR, 8'd2);   expectErr("dir2", 0, 3'd0, 8'd0);
        applyStimulus(KIND_NET, 8'd2);   expectErr("net2_first", 0, 3'd0, 8'd0);
        applyStimulus(KIND_NET, 8'd2);   expectErr("net2_again", 1, 3'd3, 8'd2);
        applyStimulus(KIND_DIR, 8'd3);   expectErr("dir3", 0, 3'd0, 8'd0);
        applyStimulus(KIND_NET, 8'd3);   expectErr("net3_first", 0, 3'd0, 8'd0);
        applyStimulus(KIND_VAR, 8'd3);   expectErr("var3_after_net", 1, 3'd4, 8'd3);
        applyStimulus(KIND_VAR, 8'd3);   expectErr("var3_mix_prio", 1, 3'd4, 8'd3);
        applyStimulus(KIND_NET, 8'd3);   expectErr("net3_mix_prio", 1, 3'd4, 8'd3);

        // Backpressure: the error record must hold while err_ready is low.
        @(posedge clk);
        #1;
        err_ready = 1'b0;
        applyStimulus(KIND_DIR, 8'd0);   expectErr("stall_load", 1, 3'd1, 8'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_ready", decl_ready, 0);
            expectErr("stall_hold", 1, 3'd1, 8'd0);
        end
        err_ready = 1'b1;
        #1;
        checkOutput("release_ready", decl_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("release_retired", err_valid, 0);

        // Retire and reload in the same cycle.
        applyStimulus(KIND_DIR, 8'd0);   expectErr("b2b_first", 1, 3'd1, 8'd0);
        checkOutput("b2b_ready", decl_ready, 1);
        applyStimulus(KIND_DIR, 8'd1);   expectErr("b2b_second", 1, 3'd1, 8'd1);

`ifndef PORT_DECL_CHECKER_SCAN_EN
        applyStimulus(KIND_END, 8'd5);
        checkOutput("end_done", done, 1);
        checkOutput("end_err_retired", err_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("end_done_pulse", done, 0);
        applyStimulus(KIND_DIR, 8'd0);   expectErr("clr_dir0", 0, 3'd0, 8'd0);
        applyStimulus(KIND_VAR, 8'd1);   expectErr("clr_var1", 0, 3'd0, 8'd0);
        applyStimulus(KIND_NET, 8'd3);   expectErr("clr_net3", 0, 3'd0, 8'd0);
        applyStimulus(KIND_DIR, 8'd0);   expectErr("clr_dir0_again", 1, 3'd1, 8'd0);
`else
        begin
            int          cycles;
            logic        got_done;
            int          events;
            logic [IDX_W-1:0] exp_missing [6] = '{8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};

            // First END flushes the current table.
            applyStimulus(KIND_END, 8'd0);
            collectUntilDone(40, cycles, got_done);
            checkOutput("scan_flush_done", got_done, 1);

            applyStimulus(KIND_DIR, 8'd0);   expectErr("scan_dir0", 0, 3'd0, 8'd0);
            applyStimulus(KIND_DIR, 8'd2);   expectErr("scan_dir2", 0, 3'd0, 8'd0);
            seen_ports.delete();
            seen_codes.delete();
            applyStimulus(KIND_END, 8'd0);
            collectUntilDone(40, cycles, got_done);
            checkOutput("scan_done", got_done, 1);
            checkOutput("scan_done_latency", cycles, NUM_PORTS + 1);
            checkOutput("scan_err_count", seen_ports.size(), 6);
            for (int i = 0; i < 6; i++) begin
                if (i < seen_ports.size()) begin
                    checkOutput("scan_err_port", seen_ports[i], exp_missing[i]);
                    checkOutput("scan_err_code", seen_codes[i], 3'd5);
                end
            end
            @(posedge clk);
            #1;
            checkOutput("scan_done_pulse", done, 0);
            applyStimulus(KIND_DIR, 8'd0);   expectErr("scan_clr_dir0", 0, 3'd0, 8'd0);

            // Reset during a scan aborts it silently.
            applyStimulus(KIND_END, 8'd0);
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst    = 1'b0;
            events = 0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (done || err_valid) events++;
            end
            checkOutput("abort_no_events", events, 0);
            checkOutput("abort_ready", decl_ready, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/port_decl_checker.md
# port_decl_checker

Streaming checker for non-ANSI port declarations in hardware. It consumes one declaration record per handshake: a port index plus its kind (direction, variable, or net). It keeps a per-port seen-table and emits one classified error record for every illegal redeclaration. The block sits directly downstream of the declaration tokenizer and upstream of the diagnostic formatter, which turns error codes into messages.

## Interface
Parameters:
- NUM_PORTS, 8, number of module ports tracked (2..256)
- IDX_W, 8, port index width; must satisfy 2**IDX_W >= NUM_PORTS

Ports:
- clk  input  1  clock, all state rising-edge
- rst  input  1  synchronous, active-high reset
- decl_valid  input  1  declaration record present
- decl_ready  output  1  record accepted this cycle when high together with decl_valid
- decl_port  input  IDX_W  port index
- decl_kind  input  2  0=DIR, 1=VAR, 2=NET, 3=END (end of module header)
- err_valid  output  1  error record present
- err_ready  input  1  consumer accepts error record
- err_code  output  3  error class, see Operation
- err_port  output  IDX_W  offending port index
- done  output  1  one-cycle pulse when a module's checking completes

## Operation
- Each port has three table bits: dir_seen, var_seen, net_seen.
- A DIR record sets dir_seen. If dir_seen was already set, the block emits code 1 PORT_MULTI ("declared multiple times").
- A VAR record sets var_seen:
  - net_seen already set: emit code 4 VAR_NET_MIX.
  - otherwise, var_seen already set: emit code 2 VAR_MULTI.
- A NET record sets net_seen:
  - var_seen already set: emit code 4 VAR_NET_MIX.
  - otherwise, net_seen already set: emit code 3 NET_MULTI.
- At most one error is emitted per record.
- DIR is independent of VAR and NET. DIR followed by VAR is legal.
- decl_port >= NUM_PORTS on DIR/VAR/NET: emit code 6 BAD_INDEX. The table is unchanged.
- END record:
  - with scan (see Configuration): enter SCAN.
  - without scan: clear the table and pulse done.
  - decl_port is ignored for END.
- States are IDLE, SCAN, FLUSH:
  - IDLE to SCAN on accepted END.
  - In SCAN, index i runs 0..NUM_PORTS-1. Port i with dir_seen=0 emits code 5 MISSING_DIR (err_port=i). i advances only once its error, if any, has been handed off.
  - SCAN to FLUSH after i=NUM_PORTS-1 is processed.
  - FLUSH clears the table, pulses done, and returns to IDLE.
- Error output is a single register stage. A record holds stable while err_valid && !err_ready.
- Code 0 is never emitted.

## Timing
- decl_ready = (state==IDLE) && (!err_valid || err_ready). It is combinational from err_ready.
- For an accepted record in cycle N:
  - table update is visible in cycle N+1;
  - any error appears with err_valid=1 in cycle N+1.
- Back-to-back records on the same port compare against the updated table, with no hazard.
- Simultaneous err_valid && err_ready and a new accepted erroring record: the old record retires and the new one loads in the same cycle. No bubble.
- Without scan, END accepted in cycle N gives done=1 in cycle N+1, with the table cleared.
- With scan and err_ready held high, END accepted in cycle N gives done in cycle N+NUM_PORTS+2.
- Reset values:
  - decl_ready=0 during rst;
  - err_valid=0, err_code=0, err_port=0, done=0;
  - table all zero, state IDLE.
- Reset mid-SCAN aborts the scan. No further errors and no done pulse.

## Configuration
- PORT_DECL_CHECKER_SCAN_EN:
  - Defined: END triggers the SCAN state and MISSING_DIR reporting.
  - Undefined: the SCAN state and scan index are not compiled. END goes straight to clear plus done. Code 5 is never produced.

## Structure
- Package port_decl_pkg holds:
  - decl_kind_e (DIR/VAR/NET/END);
  - err_code_e (NONE=0, PORT_MULTI=1, VAR_MULTI=2, NET_MULTI=3, VAR_NET_MIX=4, MISSING_DIR=5, BAD_INDEX=6);
  - state_e (IDLE/SCAN/FLUSH).
- Sub-module port_decl_table holds the NUM_PORTS x 3 flag array. It has:
  - one read/update port (old flags returned combinationally, set on write enable);
  - one scan read port;
  - a synchronous clear.

## Test plan
- DIR p0, DIR p0 -> one error: code 1, port 0. Second DIR p0 produces no VAR/NET side effects.
- DIR p1, VAR p1, VAR p1 -> one error: code 2, port 1.
- DIR p2, NET p2, NET p2, then DIR p3, NET p3, VAR p3 -> code 3 port 2, then code 4 port 3.
- err_ready held low for 5 cycles after a code-1 error -> decl_ready=0 and err_code/err_port stable throughout. Release gives retirement, and decl_ready returns the same cycle.
- Record DIR p9 with NUM_PORTS=8 -> code 6 port 9. A subsequent DIR p1 (a port with no prior DIR) raises no error, proving no aliasing.
- With the macro defined: DIR p0, DIR p2, END -> MISSING_DIR for ports 1, 3, 4, 5, 6, 7 in order, then done. A rerun of DIR p0 afterwards raises no error, showing the table was cleared. A separate run asserts rst mid-SCAN and checks that no done pulse occurs.
